// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: ez8 data-memory controller. Decodes the 8-bit data space
// into special registers, FSR pointers, an I/O hole and banked GP RAM, with
// INDF indirection, pointer post-increment, interrupt capture and a
// one-cycle read pipeline with write-to-read bypass.
module banked_mem_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_IRQ   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pause,
  input  logic               zin,
  input  logic               z_write,
  input  logic               cin,
  input  logic               c_write,
  output logic               cout,
  input  logic [7:0]         writeaddr,
  input  logic [7:0]         writedata,
  input  logic               write_en,
  input  logic [7:0]         readaddr,
  output logic [7:0]         readdata,
  input  logic               accum_write,
  output logic [7:0]         accum_out,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] NB = 3'(NUM_BANKS);

  // Architectural state
  logic [7:0] status_q, status_d;
  logic [7:0] intcon_q, intcon_d;
  logic [7:0] intstat_q, intstat_d;
  logic [7:0] fsr_q [4];
  logic [7:0] fsr_d [4];
  logic [7:0] accum_q, accum_d;

  // Read pipeline: everything needed to form readdata one cycle after issue
  logic [7:0] ra_q;
  logic [1:0] rbank_q;
  logic [7:0] spec_q, spec_d;
  logic       byp_q, byp_d;
  logic [7:0] wdata_q;

  logic [1:0]  fsr_sel;
  logic [7:0]  wea, rea;
  logic        wr, status_wr, w_gp, w_io, w_lands, ram_we;
  logic [1:0]  wbank, rbank;
  logic [7:0]  irq_ext, fsr_inc;
  logic [7:0]  woff, roff;
  logic [31:0] bank_rdata;

  // Resolve INDF, pick banks and decide whether this cycle's write lands anywhere.
  always_comb begin
    fsr_sel   = status_q[3:2];
    wea       = (writeaddr == 8'h00) ? fsr_q[fsr_sel] : writeaddr;
    rea       = (readaddr == 8'h00) ? fsr_q[fsr_sel] : readaddr;
    wr        = write_en && !pause;
    status_wr = wr && (wea == 8'h01);
    // A STATUS write steers the write-path bank in the same cycle.
    wbank     = status_wr ? writedata[6:5] : status_q[6:5];
    rbank     = status_q[6:5];
    w_gp      = (wea[7:4] != 4'h0);
    w_io      = (wea[7:3] == 5'b00001);
    // Writes to resolved 0, the I/O hole or a missing bank are dropped.
    w_lands   = wr && (wea != 8'h00) && !w_io && (!w_gp || ({1'b0, wbank} < NB));
    ram_we    = w_lands && w_gp && reset_n;
    woff      = wea - 8'h10;
    roff      = rea - 8'h10;
    irq_ext   = '0;
    irq_ext[NUM_IRQ-1:0] = irq_in;
  end

  // Next state of flags, special registers, FSRs (with post-increment) and accumulator.
  always_comb begin
    status_d = status_q;
    intcon_d = intcon_q;
    accum_d  = accum_q;
    for (int i = 0; i < 4; i++) fsr_d[i] = fsr_q[i];
    fsr_inc = 8'h00;
    // Read and write through INDF each count once; both saw the old pointer.
    if (!pause && status_q[7])
      fsr_inc = {7'b0, readaddr == 8'h00} + {7'b0, write_en && (writeaddr == 8'h00)};
    fsr_d[fsr_sel] = fsr_q[fsr_sel] + fsr_inc;
    // A direct FSR write overrides any increment of the same pointer.
    if (wr && (wea[7:2] == 6'b000001)) fsr_d[wea[1:0]] = writedata;
    if (status_wr) begin
      status_d = writedata;
    end else if (!pause) begin
      if (z_write) status_d[0] = zin;
      if (c_write) status_d[1] = cin;
    end
    if (wr && (wea == 8'h02)) intcon_d = writedata;
    // Hardware set wins over a software clear; capture runs even when paused.
    intstat_d = ((wr && (wea == 8'h03)) ? writedata : intstat_q) | irq_ext;
    if (accum_write && !pause) accum_d = writedata;
  end

  // Capture the register-side read value and the bypass decision at issue.
  always_comb begin
    spec_d = 8'h00;
    if (rea == 8'h01)                spec_d = status_q;
    else if (rea == 8'h02)           spec_d = intcon_q;
    else if (rea == 8'h03)           spec_d = intstat_q;
    else if (rea[7:2] == 6'b000001)  spec_d = fsr_q[rea[1:0]];
    byp_d = w_lands && (wea == rea) && (!w_gp || (wbank == rbank));
  end

  // State and pipeline registers; the pipeline freezes while paused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q  <= '0;
      intcon_q  <= '0;
      intstat_q <= '0;
      accum_q   <= '0;
      for (int i = 0; i < 4; i++) fsr_q[i] <= '0;
      ra_q      <= '0;
      rbank_q   <= '0;
      spec_q    <= '0;
      byp_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      status_q  <= status_d;
      intcon_q  <= intcon_d;
      intstat_q <= intstat_d;
      accum_q   <= accum_d;
      for (int i = 0; i < 4; i++) fsr_q[i] <= fsr_d[i];
      if (!pause) begin
        ra_q    <= rea;
        rbank_q <= rbank;
        spec_q  <= spec_d;
        byp_q   <= byp_d;
        wdata_q <= writedata;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      if (gi < NUM_BANKS) begin : g_ram
        logic [7:0] ram_q [240];
        logic [7:0] rdata_q;
        // One GP bank: synchronous write, registered read held while paused.
        always_ff @(posedge clk) begin
          if (ram_we && (wbank == 2'(gi))) ram_q[woff] <= writedata;
          if (!pause) rdata_q <= ram_q[roff];
        end
        assign bank_rdata[gi*8 +: 8] = rdata_q;
      end else begin : g_none
        assign bank_rdata[gi*8 +: 8] = 8'h00;
      end
    end
  endgenerate

  // Output mux: bypass, then resolved-zero, then registers / I/O, then GP bank.
  always_comb begin
    if (byp_q)                readdata = wdata_q;
    else if (ra_q == 8'h00)   readdata = 8'h00;
    else if (ra_q < 8'h10)    readdata = spec_q;
    else                      readdata = bank_rdata[{rbank_q, 3'b000} +: 8];
  end

  assign cout      = status_q[1];
  assign accum_out = accum_q;
  assign irq       = |(intcon_q & intstat_q);

endmodule

// File: doc/banked_mem_ctrl.md
# banked_mem_ctrl

Parametrised data-memory controller for the ez8 core, the successor to the fixed four-bank controller. It decodes the 8-bit data address space into special registers, indirect pointers, an I/O hole and banked general-purpose RAM. It adds indirect access through INDF with optional pointer post-increment, hardware interrupt capture and a masked interrupt request. It sits between the execute stage and the per-bank `gpmem` instances. Reads have one-cycle latency with write-to-read bypass.

## Interface
- `NUM_BANKS`, 4, number of GP banks instantiated, 1..4.
- `NUM_IRQ`, 8, number of interrupt source lines, 1..8. They map to INTSTATUS[NUM_IRQ-1:0].
- `clk` input 1: single clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `pause` input 1: when high, freezes all architectural state and the read pipeline. The only exception is IRQ capture.
- `zin`, `z_write` input 1 each: Z flag value and its write enable.
- `cin`, `c_write` input 1 each: C flag value and its write enable.
- `cout` output 1: STATUS[1].
- `writeaddr` input 8, `writedata` input 8, `write_en` input 1: write port.
- `readaddr` input 8: read address, issued in cycle N.
- `readdata` output 8: read data, valid in cycle N+1.
- `accum_write` input 1: loads `writedata` into the accumulator.
- `accum_out` output 8: accumulator value.
- `irq_in` input NUM_IRQ: level interrupt sources, sampled every clock.
- `irq` output 1: asserted when any bit of (INTCON & INTSTATUS) is set.

## Operation
- **Address map**
  - 0x00: INDF.
  - 0x01: STATUS.
  - 0x02: INTCON.
  - 0x03: INTSTATUS.
  - 0x04–0x07: FSR0–3.
  - 0x08–0x0F: I/O. Reads return 0; writes are ignored.
  - 0x10–0xFF: GP RAM, 240 bytes per bank. Bank offset = address − 0x10.
- **STATUS fields**
  - [0] Z, [1] C.
  - [3:2] FSR select. Bit [4] is reserved, reads back as written.
  - [6:5] bank. [7] AINC, the post-increment enable.
- **Effective address**
  - An access to 0x00 uses FSR[STATUS[3:2]] instead.
  - If the resolved address is 0x00 again, a read returns 0 and a write is dropped.
  - Any other resolved address is decoded normally, using the current bank.
- **Bank selection**
  - Write-path bank: if the same cycle writes STATUS, the bank is `writedata[6:5]`; otherwise it is STATUS[6:5].
  - GP accesses to a bank ≥ NUM_BANKS read 0, and writes to it are dropped.
- **Post-increment**
  - When AINC=1, each INDF access (read or write) adds 1 to the selected FSR, modulo 256.
  - A read and a write through INDF in the same cycle both use the pre-increment pointer, and the FSR advances by 2.
  - A direct write to that FSR in the same cycle takes priority: no increment is applied.
- **Flags**
  - A STATUS write in the same cycle overrides `z_write`/`c_write`.
  - Otherwise Z and C update independently.
- **Interrupts**
  - Every cycle: INTSTATUS ← (write_en && ea==0x03 ? writedata : INTSTATUS) | irq_in.
  - A hardware set therefore beats a software clear in the same cycle.
  - IRQ capture continues while `pause` is high.
- **Accumulator**: cleared by reset; otherwise loaded by `accum_write`, except while paused.
- **Read data priority**, evaluated on registered cycle-N values:
  1. Bypass, when the write was valid and the registered effective read address equals the registered effective write address and bank.
  2. Resolved address 0 → 0.
  3. Special registers, FSRs, the I/O hole (0), or the GP bank output.

## Timing
- Reset (async assert, deassert synchronised externally) sets:
  - STATUS, INTCON, INTSTATUS, FSR0–3 and the accumulator to 0.
  - The pipeline registers to zero with write-valid cleared, so `readdata`=0 and `irq`=0.
  - Reset asserted mid-access discards that access.
- **Read latency**: exactly 1 cycle.
  - Effective address, bank and FSR value are captured at issue.
  - A later FSR change does not affect an in-flight read.
- **Write latency**: registers and GP RAM update at the issuing edge. A read of the same location in the next cycle returns the new data.
- **`irq` timing**: combinational from the registered INTCON/INTSTATUS, so it asserts 1 cycle after the `irq_in` edge.
- **Pause**: while `pause`=1, `readdata` holds its value and no register, RAM, FSR or flag changes occur.

## Test plan
- **Reset values**: assert `reset_n`=0 mid-write of 0x55 to 0x20 → all registers read 0, `irq`=0, and 0x20 is unchanged after release.
- **Bank select**: write STATUS=0x20 (bank 1), then write 0xAA to 0x30 → the 0x30 write lands in bank 1 in the same cycle. Then set bank 0, read 0x30 → old bank-0 data. Set bank 1 → 0xAA.
- **Post-increment**:
  - Setup: FSR0=0x40, STATUS=0x80. Write 0x11 and then 0x22 to INDF.
  - Expected: 0x40=0x11, 0x41=0x22, FSR0=0x42.
  - Wrap case: FSR0=0xFF with one access → FSR0=0x00.
- **Bypass**: write 0x5A to 0x10 while reading 0x10 in the same cycle → `readdata` on the next cycle is 0x5A.
- **Interrupts**:
  - Setup: INTCON=0x04, pulse `irq_in`[2] → INTSTATUS=0x04 and `irq`=1 one cycle later.
  - Write INTSTATUS=0 while `irq_in`[2] is still high → stays 0x04.
- **Flags and pause**:
  - `z_write`=1 together with a STATUS write of 0x02 → STATUS=0x02.
  - `pause`=1 with `write_en` to 0x20 → no update, and `readdata` is held.
